// File: rtl/bitalu_n_pipe.sv
// Two-stage pipelined N-bit ALU with post-ALU shifter and valid/ready handshakes.
// Stage 1 holds the accepted operation; stage 2 holds the registered result and flags.
module bitalu_n_pipe #(
    parameter int WIDTH   = 16,
    parameter int SLL_AMT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             INVA,
    input  logic             ENA,
    input  logic             ENB,
    input  logic             F0,
    input  logic             F1,
    input  logic             CIN,
    input  logic             SLL,
    input  logic             SRA1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             COUT,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             ERR
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_inva;
    logic             r_ena;
    logic             r_enb;
    logic [1:0]       r_f;
    logic             r_cin;
    logic             r_sll;
    logic             r_sra1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic             r_err;

    logic             w_adv2;
    logic             w_accept;
    logic [WIDTH-1:0] w_ae;
    logic [WIDTH-1:0] w_be;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_shift;
    logic             w_cout;
    logic             w_v;
    logic             w_err;

    assign w_adv2   = ~r_out_valid | out_ready;
    assign in_ready = ~r_s1_valid | w_adv2;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_inva     <= 1'b0;
            r_ena      <= 1'b0;
            r_enb      <= 1'b0;
            r_f        <= 2'b00;
            r_cin      <= 1'b0;
            r_sll      <= 1'b0;
            r_sra1     <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_a        <= A;
            r_b        <= B;
            r_inva     <= INVA;
            r_ena      <= ENA;
            r_enb      <= ENB;
            r_f        <= {F1, F0};
            r_cin      <= CIN;
            r_sll      <= SLL;
            r_sra1     <= SRA1;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_comb begin
        w_ae  = (r_ena ? r_a : '0) ^ {WIDTH{r_inva}};
        w_be  = r_enb ? r_b : '0;
        w_sum = {1'b0, w_ae} + {1'b0, w_be} + {{WIDTH{1'b0}}, r_cin};
        case (r_f)
            2'b00:   w_alu = w_ae & w_be;
            2'b01:   w_alu = w_ae | w_be;
            2'b10:   w_alu = ~w_be;
            default: w_alu = w_sum[WIDTH-1:0];
        endcase
        w_cout = (r_f == 2'b11) & w_sum[WIDTH];
        w_v    = (r_f == 2'b11) & (w_ae[WIDTH-1] == w_be[WIDTH-1])
                 & (w_sum[WIDTH-1] != w_ae[WIDTH-1]);
        // Both shift requests at once is illegal: pass through and flag it.
        w_err  = r_sll & r_sra1;
        case ({r_sll, r_sra1})
            2'b10:   w_shift = w_alu << SLL_AMT;
            2'b01:   w_shift = {w_alu[WIDTH-1], w_alu[WIDTH-1:1]};
            default: w_shift = w_alu;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_shift;
                r_cout   <= w_cout;
                r_z      <= (w_shift == '0);
                r_n      <= w_shift[WIDTH-1];
                r_v      <= w_v;
                r_err    <= w_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign COUT      = r_cout;
    assign Z         = r_z;
    assign N         = r_n;
    assign V         = r_v;
    assign ERR       = r_err;

endmodule

// File: tb/tb_bitalu_n_pipe.sv
// Directed vector bench for bitalu_n_pipe (WIDTH=16, SLL_AMT=8) with pipeline corner sequences.
module tb_bitalu_n_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B, Result;
    logic        INVA, ENA, ENB, F0, F1, CIN, SLL, SRA1;
    logic        COUT, Z, N, V, ERR;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        inva, ena, enb;
        logic [1:0]  f;
        logic        cin, sll, sra;
        logic [15:0] res;
        logic        cout, z, n, v, err;
    } vec_t;

    vec_t vecs[16];

    bitalu_n_pipe #(.WIDTH(16), .SLL_AMT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .INVA(INVA), .ENA(ENA), .ENB(ENB), .F0(F0), .F1(F1),
        .CIN(CIN), .SLL(SLL), .SRA1(SRA1), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .COUT(COUT), .Z(Z), .N(N),
        .V(V), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic inva,
                          input logic ena, input logic enb, input logic [1:0] f,
                          input logic cin, input logic sll, input logic sra);
        A = a; B = b; INVA = inva; ENA = ena; ENB = enb;
        F1 = f[1]; F0 = f[0]; CIN = cin; SLL = sll; SRA1 = sra;
    endtask

    task automatic scramble();
        set_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        set_op(vecs[i].a, vecs[i].b, vecs[i].inva, vecs[i].ena, vecs[i].enb,
               vecs[i].f, vecs[i].cin, vecs[i].sll, vecs[i].sra);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check($sformatf("v%0d in_ready", i), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        #1 check($sformatf("v%0d early out_valid", i), out_valid, 0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d out_valid", i), out_valid, 1);
        check($sformatf("v%0d Result", i), Result, vecs[i].res);
        check($sformatf("v%0d flags{C,Z,N,V,E}", i), {COUT, Z, N, V, ERR},
              {vecs[i].cout, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].err});
    endtask

    initial begin
        //           a         b     inva ena enb f     cin sll sra  res    cout z n v err
        vecs[0]  = '{16'h0003, 16'h0005, 0, 1, 1, 2'd3, 1, 0, 0, 16'h0009, 0, 0, 0, 0, 0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 0, 1, 1, 2'd3, 0, 0, 0, 16'h8000, 0, 0, 1, 1, 0};
        vecs[2]  = '{16'h0001, 16'h0000, 1, 1, 0, 2'd3, 1, 0, 0, 16'hFFFF, 0, 0, 1, 0, 0};
        vecs[3]  = '{16'h00A5, 16'h0000, 0, 1, 0, 2'd1, 0, 1, 0, 16'hA500, 0, 0, 1, 0, 0};
        vecs[4]  = '{16'h8004, 16'h0000, 0, 1, 0, 2'd1, 0, 0, 1, 16'hC002, 0, 0, 1, 0, 0};
        vecs[5]  = '{16'h8004, 16'h0000, 0, 1, 0, 2'd1, 0, 1, 1, 16'h8004, 0, 0, 1, 0, 1};
        vecs[6]  = '{16'h1234, 16'h5678, 0, 0, 0, 2'd3, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        vecs[7]  = '{16'h1234, 16'h5678, 1, 0, 0, 2'd3, 0, 0, 0, 16'hFFFF, 0, 0, 1, 0, 0};
        vecs[8]  = '{16'hF0F0, 16'hFF00, 0, 1, 1, 2'd0, 0, 0, 0, 16'hF000, 0, 0, 1, 0, 0};
        vecs[9]  = '{16'h1111, 16'h00FF, 0, 1, 1, 2'd2, 0, 0, 0, 16'hFF00, 0, 0, 1, 0, 0};
        vecs[10] = '{16'hFFFF, 16'h0001, 0, 1, 1, 2'd3, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0};
        vecs[11] = '{16'h8000, 16'h8000, 0, 1, 1, 2'd3, 0, 0, 0, 16'h0000, 1, 1, 0, 1, 0};
        vecs[12] = '{16'hFFFF, 16'hFFFF, 0, 1, 1, 2'd3, 0, 0, 1, 16'hFFFF, 1, 0, 1, 0, 0};
        vecs[13] = '{16'h1234, 16'h0000, 0, 1, 1, 2'd1, 0, 1, 0, 16'h3400, 0, 0, 0, 0, 0};
        vecs[14] = '{16'h0080, 16'h0080, 0, 1, 1, 2'd3, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0};
        vecs[15] = '{16'h000F, 16'h0003, 1, 1, 1, 2'd3, 0, 0, 0, 16'hFFF3, 0, 0, 1, 0, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_op(16'h0, 16'h0, 0, 0, 0, 2'd0, 0, 0, 0);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset Result", Result, 16'h0);
        check("reset flags", {COUT, Z, N, V, ERR}, 5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) run_vec(i);

        // Back-to-back stream: op j accepted at edge j, visible after edge j+1.
        for (int j = 0; j < 11; j++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (j < 8) begin
                set_op(16'h0100 + 16'(j), 16'h0, 0, 1, 0, 2'd1, 0, 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
                scramble();
            end
            #1;
            if (j < 8) check($sformatf("stream%0d in_ready", j), in_ready, 1);
            if (j >= 2 && j < 10) begin
                check($sformatf("stream%0d out_valid", j), out_valid, 1);
                check($sformatf("stream%0d Result", j), Result, 16'h0100 + 16'(j - 2));
            end else begin
                check($sformatf("stream%0d idle", j), out_valid, 0);
            end
        end

        // Stall with both stages full, then drain.
        @(negedge clk);
        set_op(16'h0201, 16'h0, 0, 1, 0, 2'd1, 0, 0, 0); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        set_op(16'h0202, 16'h0, 0, 1, 0, 2'd1, 0, 0, 0);
        @(negedge clk);
        set_op(16'h0203, 16'h0, 0, 1, 0, 2'd1, 0, 0, 0); out_ready = 1'b0;
        #1;
        check("stall in_ready", in_ready, 0);
        check("stall Result", Result, 16'h0201);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold%0d in_ready", k), in_ready, 0);
            check($sformatf("hold%0d out", k), {out_valid, Result, COUT, Z, N, V, ERR},
                  {1'b1, 16'h0201, 5'b00000});
        end
        out_ready = 1'b1;
        #1 check("release in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        #1 check("drain Result 2", {out_valid, Result}, {1'b1, 16'h0202});
        @(negedge clk);
        #1 check("drain Result 3", {out_valid, Result}, {1'b1, 16'h0203});
        @(negedge clk);
        #1 check("drain empty", out_valid, 0);

        // Reset mid-flight with both stages full.
        out_ready = 1'b0;
        set_op(16'h0301, 16'h0, 0, 1, 0, 2'd1, 0, 0, 0); in_valid = 1'b1;
        @(negedge clk);
        set_op(16'h0302, 16'h0, 0, 1, 0, 2'd1, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full in_ready", in_ready, 0);
        check("full out", {out_valid, Result}, {1'b1, 16'h0301});
        #1 rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst Result", Result, 16'h0);
        check("async rst flags", {COUT, Z, N, V, ERR}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 check("rst release in_ready", in_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check($sformatf("after rst quiet%0d", k), out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
